// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: SIE transmit sequencer for handshakes and IN data packets (PID, payload, CRC16, IPG)
// Ports: clk/reset_n (async active-low); hs_req/hs_pid handshake request; in_req/in_ep IN token;
//   ack_rcvd/toggle_clr DATA0/1 toggle control; ep_t* per-endpoint byte streams; ep_halt;
//   tx_data/tx_valid/tx_ready PHY port; busy (not IDLE); underrun (stream ran dry mid-packet).
// Optional: define USB_TX_HALT_EN to answer IN tokens on halted endpoints with STALL.
module usb_tx_scheduler #(
  parameter int NUM_EP = 4,
  parameter int MAX_PKT = 8,
  parameter int IPG_CYCLES = 16,
  localparam int EPW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hs_req,
  input  logic [1:0]        hs_pid,
  input  logic              in_req,
  input  logic [EPW-1:0]    in_ep,
  input  logic              ack_rcvd,
  input  logic [NUM_EP-1:0] toggle_clr,
  input  logic [NUM_EP-1:0] ep_tvalid,
  input  logic [8*NUM_EP-1:0] ep_tdata,
  input  logic [NUM_EP-1:0] ep_tlast,
  output logic [NUM_EP-1:0] ep_tready,
  input  logic [NUM_EP-1:0] ep_halt,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              underrun
);
  typedef enum logic [2:0] {IDLE, PID, PAYLOAD, CRC_LO, CRC_HI, GAP} state_t;
  state_t state, state_n;
  logic hs_pend, in_pend, data_pkt, sel_data, seen, bad, halt, grant, take, under;
  logic [1:0] hs_pid_q;
  logic [EPW-1:0] in_ep_q, cur_ep, last_ep;
  logic [7:0] pid_q, sel_pid, ep_byte;
  logic [15:0] crc, crc_tx, cnt;
  logic [NUM_EP-1:0] toggle, toggle_n;

  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

`ifdef USB_TX_HALT_EN
  assign halt = ep_halt[in_ep_q];
`else
  logic unused_halt;
  assign halt = 1'b0;
  assign unused_halt = ^ep_halt;
`endif

  assign grant = state == IDLE && (hs_pend || in_pend);
  assign ep_byte = ep_tdata[{cur_ep, 3'b000} +: 8];
  // a packet that underran carries the uncomplemented CRC so the host rejects it
  assign crc_tx = bad ? crc : ~crc;
  assign sel_data = !hs_pend && !halt && ep_tvalid[in_ep_q];
  assign sel_pid = hs_pend ? (hs_pid_q == 2'b00 ? 8'hD2 : hs_pid_q == 2'b01 ? 8'h5A : 8'h1E)
                 : halt ? 8'h1E : !ep_tvalid[in_ep_q] ? 8'h5A : toggle[in_ep_q] ? 8'h4B : 8'hC3;
  assign busy = state != IDLE;
  assign underrun = under;

  always_comb begin
    toggle_n = toggle;
    for (int i = 0; i < NUM_EP; i++)
      toggle_n[i] = toggle_clr[i] ? 1'b0 : (ack_rcvd && seen && last_ep == EPW'(i)) ? ~toggle[i] : toggle[i];
  end

  always_comb begin
    state_n = state;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    ep_tready = '0;
    take = 1'b0;
    under = 1'b0;
    case (state)
      IDLE: state_n = grant ? PID : IDLE;
      PID: begin
        tx_valid = 1'b1;
        tx_data = pid_q;
        if (tx_ready) state_n = data_pkt ? PAYLOAD : GAP;
      end
      PAYLOAD: begin
        tx_valid = 1'b1;
        if (ep_tvalid[cur_ep]) begin
          tx_data = ep_byte;
          if (tx_ready) begin
            ep_tready[cur_ep] = 1'b1;
            take = 1'b1;
            if (ep_tlast[cur_ep] || cnt == 16'(MAX_PKT - 1)) state_n = CRC_LO;
          end
        end else begin
          // stream ran dry: this beat already carries the (bad) CRC low byte
          under = 1'b1;
          tx_data = crc[7:0];
          state_n = tx_ready ? CRC_HI : CRC_LO;
        end
      end
      CRC_LO: begin
        tx_valid = 1'b1;
        tx_data = crc_tx[7:0];
        if (tx_ready) state_n = CRC_HI;
      end
      CRC_HI: begin
        tx_valid = 1'b1;
        tx_data = crc_tx[15:8];
        if (tx_ready) state_n = GAP;
      end
      GAP: state_n = cnt == 16'(IPG_CYCLES - 1) ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      hs_pend <= 1'b0;
      in_pend <= 1'b0;
      hs_pid_q <= 2'b00;
      in_ep_q <= '0;
      cur_ep <= '0;
      last_ep <= '0;
      pid_q <= 8'h00;
      data_pkt <= 1'b0;
      seen <= 1'b0;
      bad <= 1'b0;
      crc <= 16'hFFFF;
      cnt <= '0;
      toggle <= '0;
    end else begin
      state <= state_n;
      hs_pend <= (hs_req && hs_pid != 2'b11) || (hs_pend && !grant);
      in_pend <= in_req || (in_pend && !(grant && !hs_pend));
      if (hs_req && hs_pid != 2'b11) hs_pid_q <= hs_pid;
      if (in_req) in_ep_q <= in_ep;
      toggle <= toggle_n;
      cnt <= (grant || (state_n == GAP && state != GAP)) ? '0 : (state == GAP || take) ? cnt + 16'd1 : cnt;
      if (grant) begin
        pid_q <= sel_pid;
        data_pkt <= sel_data;
        cur_ep <= in_ep_q;
        crc <= 16'hFFFF;
        bad <= 1'b0;
        if (sel_data) begin
          last_ep <= in_ep_q;
          seen <= 1'b1;
        end
      end
      if (take) crc <= crc16(crc, ep_byte);
      if (under) bad <= 1'b1;
    end
  end
endmodule
